// File: rtl/result_serial_tx_if.sv
// Handshake/data bundle between the logic processor top level and result_serial_tx.
// The slave modport is the transmitter's view; the master modport is the requester's.
interface result_serial_tx_if;
    logic       Start;
    logic [7:0] Data_A;
    logic [7:0] Data_B;
    logic       TxD;
    logic       Busy;
    logic       Done;

    modport master (
        output Start,
        output Data_A,
        output Data_B,
        input  TxD,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Start,
        input  Data_A,
        input  Data_B,
        output TxD,
        output Busy,
        output Done
    );
endinterface

// File: rtl/result_serial_tx.sv
// UART-style transmitter sending register A then register B as one two-byte frame.
// Define TX_PARITY_EN to insert an even-parity bit after the data bits of each byte.
module result_serial_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              Clk,
    input  logic              Reset_n,
    result_serial_tx_if.slave bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        FINISH     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        FINISH    = 3'd4
    } state_t;
`endif

    state_t            state_reg,    state_next;
    logic [BAUD_W-1:0] baud_reg,     baud_next;
    logic [2:0]        bit_idx_reg,  bit_idx_next;
    logic [7:0]        shift_reg,    shift_next;
    logic [7:0]        b_reg,        b_next;
    logic              byte_sel_reg, byte_sel_next;
    logic              tx_reg,       tx_next;
`ifdef TX_PARITY_EN
    logic              par_reg,      par_next;
`endif

    logic baud_last;
    assign baud_last = (baud_reg == BAUD_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            b_reg        <= '0;
            byte_sel_reg <= 1'b0;
            tx_reg       <= 1'b1;
`ifdef TX_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            b_reg        <= b_next;
            byte_sel_reg <= byte_sel_next;
            tx_reg       <= tx_next;
`ifdef TX_PARITY_EN
            par_reg      <= par_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        b_next        = b_reg;
        byte_sel_next = byte_sel_reg;
        tx_next       = 1'b1;
`ifdef TX_PARITY_EN
        par_next      = par_reg;
`endif

        case (state_reg)
            IDLE: begin
                baud_next     = '0;
                bit_idx_next  = '0;
                byte_sel_next = 1'b0;
                if (bus.Start) begin
                    shift_next = bus.Data_A;
                    b_next     = bus.Data_B;
`ifdef TX_PARITY_EN
                    par_next   = ^bus.Data_A;
`endif
                    state_next = START_BIT;
                end
            end

            START_BIT: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = DATA_BITS;
                end else begin
                    baud_next  = baud_reg + 1'b1;
                end
            end

            DATA_BITS: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
`ifdef TX_PARITY_EN
                        state_next   = PARITY_BIT;
`else
                        state_next   = STOP_BIT;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

`ifdef TX_PARITY_EN
            PARITY_BIT: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = STOP_BIT;
                end else begin
                    baud_next  = baud_reg + 1'b1;
                end
            end
`endif

            STOP_BIT: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Byte A done: chain straight into byte B with no idle gap.
                    if (!byte_sel_reg) begin
                        byte_sel_next = 1'b1;
                        shift_next    = b_reg;
`ifdef TX_PARITY_EN
                        par_next      = ^b_reg;
`endif
                        state_next    = START_BIT;
                    end else begin
                        state_next    = FINISH;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The line level is computed for the upcoming state so TxD leaves a flop.
        case (state_next)
            START_BIT:  tx_next = 1'b0;
            DATA_BITS:  tx_next = shift_next[0];
`ifdef TX_PARITY_EN
            PARITY_BIT: tx_next = par_next;
`endif
            default:    tx_next = 1'b1;
        endcase
    end

    assign bus.TxD  = tx_reg;
    assign bus.Busy = (state_reg != IDLE) && (state_reg != FINISH);
    assign bus.Done = (state_reg == FINISH);

endmodule

// File: tb/tb_result_serial_tx.sv
// Scoreboard bench for result_serial_tx: expected serial bits are queued when a frame
// is requested and popped as the line is sampled mid-bit.
module tb_result_serial_tx;

    localparam int C = 4;
`ifdef TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME  = 2 * BITS * C;
    localparam int PERIOD = FRAME + 2;

    logic Clk = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;
    logic sb[$];

    result_serial_tx_if bus ();

    result_serial_tx #(.CLKS_PER_BIT(C)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic push_byte(input logic [7:0] d);
        sb.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb.push_back(d[i]);
`ifdef TX_PARITY_EN
        sb.push_back(^d);
`endif
        sb.push_back(1'b1);
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        bus.Start   = 1'b1;
        bus.Data_A  = 8'h5A;
        bus.Data_B  = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if (bus.TxD !== 1'b1) begin bad++; $display("FAIL reset_txd cyc%0d got=%b want=1", i, bus.TxD); end
            total++;
            if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc%0d got=%b want=0", i, bus.Busy); end
            total++;
            if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done cyc%0d got=%b want=0", i, bus.Done); end
        end
        bus.Start = 1'b0;
        Reset_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if (bus.Busy !== 1'b0 || bus.TxD !== 1'b1) begin
                bad++;
                $display("FAIL post_reset_idle cyc%0d busy=%b txd=%b want busy=0 txd=1", i, bus.Busy, bus.TxD);
            end
        end
        $display("test_reset finished");
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input bit lockout, input string name);
        int   busy_cnt = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        int   bitno    = 0;
        logic exp;
        push_byte(a);
        push_byte(b);
        @(negedge Clk);
        bus.Data_A = a;
        bus.Data_B = b;
        bus.Start  = 1'b1;
        @(posedge Clk);
        for (int cyc = 1; cyc <= FRAME + 4; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) bus.Start = 1'b0;
            if (lockout && cyc == 20) begin bus.Start = 1'b1; bus.Data_A = 8'hFF; end
            if (lockout && cyc == 21) bus.Start = 1'b0;
            if (bus.Busy === 1'b1) busy_cnt++;
            if (bus.Done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (cyc <= FRAME && ((cyc - 1) % C) == C / 2) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s bit%0d got=%b want=<queue empty>", name, bitno, bus.TxD);
                end else begin
                    exp = sb.pop_front();
                    if (bus.TxD !== exp) begin
                        bad++;
                        $display("FAIL %s bit%0d got=%b want=%b", name, bitno, bus.TxD, exp);
                    end
                end
                bitno++;
            end
        end
        total++;
        if (busy_cnt != FRAME) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cnt, FRAME); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL %s done_count got=%0d want=1", name, done_cnt); end
        total++;
        if (done_cyc != FRAME + 1) begin bad++; $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, FRAME + 1); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL %s leftover_bits got=%0d want=0", name, sb.size()); end
        sb.delete();
        $display("%s frame A=%02h B=%02h busy=%0d done_at=%0d", name, a, b, busy_cnt, done_cyc);
    endtask

    task automatic test_basic();
        run_frame(8'h33, 8'hA5, 1'b0, "basic");
        run_frame(8'h81, 8'h7E, 1'b0, "basic2");
    endtask

    task automatic test_lockout();
        run_frame(8'h33, 8'hA5, 1'b1, "lockout");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] a = 8'h33;
        @(negedge Clk);
        bus.Data_A = a;
        bus.Data_B = 8'hA5;
        bus.Start  = 1'b1;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) bus.Start = 1'b0;
        end
        // Cycle 30 lies in stream slot 7, i.e. data bit 6 of byte A.
        total++;
        if (bus.TxD !== a[6]) begin bad++; $display("FAIL midreset_pre_txd got=%b want=%b", bus.TxD, a[6]); end
        Reset_n = 1'b0;
        #1;
        total++;
        if (bus.TxD !== 1'b1) begin bad++; $display("FAIL midreset_async_txd got=%b want=1", bus.TxD); end
        total++;
        if (bus.Busy !== 1'b0) begin bad++; $display("FAIL midreset_async_busy got=%b want=0", bus.Busy); end
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            total++;
            if (bus.TxD !== 1'b1 || bus.Busy !== 1'b0) begin
                bad++;
                $display("FAIL midreset_after cyc%0d txd=%b busy=%b want txd=1 busy=0", i, bus.TxD, bus.Busy);
            end
        end
        $display("reset_mid_frame finished");
    endtask

    task automatic test_back_to_back();
        int   done_cnt = 0;
        int   busy_late = 0;
        int   f;
        int   l;
        logic exp;
        for (int k = 0; k < 3; k++) begin
            push_byte(8'h00);
            push_byte(8'hFF);
        end
        @(negedge Clk);
        bus.Data_A = 8'h00;
        bus.Data_B = 8'hFF;
        bus.Start  = 1'b1;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 3 * PERIOD + 4; cyc++) begin
            @(negedge Clk);
            if (cyc == 3 * PERIOD - 1) bus.Start = 1'b0;
            f = (cyc - 1) / PERIOD;
            l = cyc - f * PERIOD;
            if (bus.Done === 1'b1) begin
                total++;
                if (cyc != done_cnt * PERIOD + FRAME + 1) begin
                    bad++;
                    $display("FAIL b2b_done_cycle got=%0d want=%0d", cyc, done_cnt * PERIOD + FRAME + 1);
                end
                done_cnt++;
            end
            if (f >= 3 && bus.Busy === 1'b1) busy_late++;
            if (f < 3 && l <= FRAME && ((l - 1) % C) == C / 2) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_bit f%0d l%0d got=%b want=<queue empty>", f, l, bus.TxD);
                end else begin
                    exp = sb.pop_front();
                    if (bus.TxD !== exp) begin
                        bad++;
                        $display("FAIL b2b_bit f%0d l%0d got=%b want=%b", f, l, bus.TxD, exp);
                    end
                end
            end
        end
        total++;
        if (done_cnt != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", done_cnt); end
        total++;
        if (busy_late != 0) begin bad++; $display("FAIL b2b_extra_frame busy_cycles got=%0d want=0", busy_late); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover_bits got=%0d want=0", sb.size()); end
        sb.delete();
        $display("back_to_back frames=%0d period=%0d", done_cnt, PERIOD);
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        run_frame(8'h07, 8'h03, 1'b0, "parity");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_lockout();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_serial_tx.md
Name: result_serial_tx

Overview:
- Bit-serial transmitter for the 8-bit logic processor; carries register contents out of the FPGA the way switches and buttons carry them in.
- On a Start pulse it captures the A and B register values. It then sends them on a single UART-style line: byte A first, then byte B.
- Sits beside the processor top level; Data_A/Data_B connect to the Aval/Bval nets, and Start comes from a synchronized, debounced push button.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  synchronized active-high request; level sampled each cycle
- Data_A  input  8  first byte to send (register A)
- Data_B  input  8  second byte to send (register B)
- TxD  output  1  serial line, idle high
- Busy  output  1  high while a two-byte frame is in progress
- Done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (Reset_n low, takes effect immediately, async): state=IDLE, TxD=1, Busy=0, Done=0, all counters and the shift register cleared. Reset mid-frame aborts it; no partial byte resumes after release.
- States: IDLE, START_BIT, DATA_BITS, [PARITY_BIT], STOP_BIT, FINISH.
- IDLE: TxD=1, Busy=0. On a rising edge with Start=1, Data_A and Data_B are latched, state goes to START_BIT, and Busy=1 from the next cycle. The TxD falling edge appears in that same next cycle, giving one cycle of latency from the Start sample.
- Start is level-sensitive only in IDLE. A Start held high across completion starts a new frame on the cycle after FINISH. Start while Busy=1 is ignored; latched data is unaffected by later Data_A/Data_B changes.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1; each serial bit is held exactly CLKS_PER_BIT cycles. The counter width is the clog2 of CLKS_PER_BIT; it wraps to 0 on every bit boundary.
- START_BIT: TxD=0 for one bit time, then DATA_BITS.
- DATA_BITS: TxD = shift_reg[0], LSB first. Shift right on each bit boundary. A 3-bit index counts 0..7, and after bit 7 the state advances.
- STOP_BIT: TxD=1 for one bit time. If the byte just sent was A, load B into the shift register and return to START_BIT (no idle gap). If the byte was B, go to FINISH.
- FINISH: a single cycle with Done=1 and Busy=0; TxD=1; next state IDLE. Busy falls in the same cycle Done rises.
- Frame length: 2 x 10 bit times = 20*CLKS_PER_BIT cycles with Busy=1 (22*CLKS_PER_BIT with parity).
- A byte-select flag (0=A, 1=B) tracks the current byte and is cleared on entering IDLE.
- No glitches on TxD: TxD is driven from a register, never combinationally.

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: a PARITY_BIT state is inserted between DATA_BITS and STOP_BIT for each byte. It sends even parity (XOR of the 8 data bits) for one bit time, so each byte is 11 bits.
- Undefined: no parity state, 10 bits per byte; the state encoding omits PARITY_BIT entirely.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with Start=1 -> TxD=1, Busy=0, Done=0 throughout; no frame starts until Reset_n=1.
- Basic frame, CLKS_PER_BIT=4, Data_A=8'h33, Data_B=8'hA5, Start pulsed 1 cycle -> TxD sampled mid-bit reads 0,1,1,0,0,1,1,0,0,1 then 0,1,0,1,0,0,1,0,1,1. Busy high for exactly 80 cycles; Done pulses once at cycle 81.
- Busy lockout: pulse Start again 20 cycles into the frame with Data_A changed to 8'hFF -> bitstream unchanged from the previous case; Done pulses exactly once.
- Reset mid-frame: assert Reset_n=0 at cycle 30 of a frame -> TxD=1 and Busy=0 asynchronously (before the next edge). After release, TxD stays 1 until a new Start.
- Back-to-back: Start held high continuously, Data_A=8'h00, Data_B=8'hFF -> consecutive frames separated by the 1-cycle FINISH plus 1 IDLE sample. Done pulses every 82 cycles (CLKS_PER_BIT=4).
- TX_PARITY_EN defined, Data_A=8'h07, Data_B=8'h03 -> parity bits 1 then 0 in bit slot 9 of each byte; Busy high 88 cycles.
